// File: rtl/md_unit_e.sv
// rtl/md_unit_e.sv - EX-stage multiply/divide unit holding the HI/LO registers
//
// Purpose: accepts mult/multu/div/divu on a one-cycle start, keeps busy high
// for a fixed latency, then commits the 64-bit result to HI/LO. Services
// mthi/mtlo writes while idle.
//
// Ports:
//   clk    in   1   clock, rising edge
//   reset  in   1   synchronous, active-high
//   start  in   1   start qualifier for mult/multu/div/divu
//   md_op  in   2   00 mult, 01 multu, 10 div, 11 divu
//   a      in  32   operand rs; mthi/mtlo write data
//   b      in  32   operand rt
//   mthi   in   1   write a to HI
//   mtlo   in   1   write a to LO
//   busy   out  1   operation in flight
//   hi     out 32   HI register
//   lo     out 32   LO register

module md_unit_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [31:0]   p_hi, p_lo, p_hi_n, p_lo_n;
  logic [31:0]   hi_n, lo_n;

  // Arithmetic on the live operands; only sampled on an accepted start.
  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b, den_s, den_u;
  logic [31:0] uq, ur, sq, sr, udq, udr;
  logic [63:0] result;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide done on magnitudes so 0x80000000 / -1 wraps cleanly to
  // 0x80000000 instead of overflowing.
  assign mag_a = a[31] ? (~a + 32'd1) : a;
  assign mag_b = b[31] ? (~b + 32'd1) : b;
  assign den_s = (b == 32'd0) ? 32'd1 : mag_b;
  assign den_u = (b == 32'd0) ? 32'd1 : b;
  assign uq    = mag_a / den_s;
  assign ur    = mag_a % den_s;
  assign sq    = (a[31] ^ b[31]) ? (~uq + 32'd1) : uq;
  assign sr    = a[31] ? (~ur + 32'd1) : ur;
  assign udq   = a / den_u;
  assign udr   = a % den_u;

  // A divide by zero pends the current HI/LO, so completion rewrites the old
  // values; HI/LO cannot change while busy, so nothing is lost.
  always_comb begin
    result = 64'd0;
    case (md_op)
      2'b00:   result = prod_s;
      2'b01:   result = prod_u;
      2'b10:   result = (b == 32'd0) ? {hi, lo} : {sr, sq};
      default: result = (b == 32'd0) ? {hi, lo} : {udr, udq};
    endcase
  end

  always_comb begin
    state_n = state;
    count_n = count;
    p_hi_n  = p_hi;
    p_lo_n  = p_lo;
    hi_n    = hi;
    lo_n    = lo;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_BUSY;
          count_n = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          p_hi_n  = result[63:32];
          p_lo_n  = result[31:0];
        end else if (mthi) begin
          hi_n = a;
        end else if (mtlo) begin
          lo_n = a;
        end
      end
      default: begin
        // start/mthi/mtlo are all dropped while busy.
        count_n = count - CW'(1);
        if (count == CW'(1)) begin
          state_n = S_IDLE;
          hi_n    = p_hi;
          lo_n    = p_lo;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_n;
      count <= count_n;
      p_hi  <= p_hi_n;
      p_lo  <= p_lo_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

  assign busy = (state == S_BUSY);

endmodule

// File: tb/tb_md_unit_e.sv
// tb/tb_md_unit_e.sv - directed self-checking bench for md_unit_e

module tb_md_unit_e;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_pass   = 0;

  md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, optionally inject a start(divu 9/3)+mtlo during busy
  // cycles 2-3, and check latency, mid-op stability and final HI/LO.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] va, input logic [31:0] vb,
                        input int n, input bit inject,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi, old_lo;
    int cnt;
    old_hi = hi;
    old_lo = lo;
    start = 1'b1; md_op = op; a = va; b = vb;
    tick();
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h0000_0000;
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      if (cnt == 3) begin
        check({tag, " mid hi"}, hi, old_hi);
        check({tag, " mid lo"}, lo, old_lo);
      end
      if (inject && (cnt == 1 || cnt == 2)) begin
        start = 1'b1; md_op = 2'b11; a = 32'd9; b = 32'd3; mtlo = 1'b1;
      end else begin
        start = 1'b0; mtlo = 1'b0;
      end
      tick();
    end
    start = 1'b0; mtlo = 1'b0;
    check({tag, " busy cycles"}, 32'(cnt), 32'(n));
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 2'b00; a = 32'd0; b = 32'd0;
    mthi = 1'b0; mtlo = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);

    run_op("mult -2*3", 2'b00, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu 7/2", 2'b11, 32'd7, 32'd2, 10, 1'b0, 32'd1, 32'd3);

    // mthi beats mtlo in the same cycle.
    mthi = 1'b1; mtlo = 1'b1; a = 32'h0000_AAAA;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    check("prio hi", hi, 32'h0000_AAAA);
    check("prio lo", lo, 32'd3);

    mthi = 1'b1; a = 32'h0000_1234;
    tick();
    mthi = 1'b0; mtlo = 1'b1; a = 32'h0000_5678;
    tick();
    mtlo = 1'b0;
    check("mthi", hi, 32'h0000_1234);
    check("mtlo", lo, 32'h0000_5678);

    run_op("div by 0", 2'b10, 32'd100, 32'd0, 10, 1'b0, 32'h0000_1234, 32'h0000_5678);
    run_op("mult ignore", 2'b00, 32'd2, 32'd3, 5, 1'b1, 32'd0, 32'd6);

    // Reset mid-divide aborts it for good.
    start = 1'b1; md_op = 2'b10; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort hi", hi, 32'd0);
    check("abort lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("abort late hi", hi, 32'd0);
    check("abort late lo", lo, 32'd0);
    check("abort late busy", {31'd0, busy}, 32'd0);

    run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, 32'd0, 32'h8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
